// File: rtl/ttl74259_sync_pkg.sv
// Shared definitions for the ttl74259_sync addressable latch.
package ttl74259_sync_pkg;

    // Mode encodings of the latch control input
    typedef enum logic [1:0] {
        HOLD  = 2'b00,
        LATCH = 2'b01,
        DEMUX = 2'b10,
        CLEAR = 2'b11
    } mode_e;

    // True for the two modes that perform a write when En is high
    function automatic logic is_write_mode(input mode_e m);
        return (m == LATCH) || (m == DEMUX);
    endfunction

endpackage

// File: rtl/ttl74259_sync_scan_ptr.sv
// Internal scan pointer with wrap detection; Done pulses the cycle after the
// scan write that used the all-ones address.
import ttl74259_sync_pkg::*;

module scan_ptr #(
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] ptr,
    output logic             done
);

    // Pointer advances on each scan write and wraps modulo 2**SEL_W
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr  <= '0;
            done <= 1'b0;
        end else begin
            done <= inc && (ptr == '1);
            if (inc) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttl74259_sync.sv
// Synchronous 74259-style 8-bit addressable latch with optional scan pointer.
import ttl74259_sync_pkg::*;

module ttl74259_sync #(
    parameter int unsigned SEL_W = 3
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  D,
    input  logic [SEL_W-1:0]      S,
    input  logic                  En,
    input  logic [1:0]            Mode,
    input  logic                  Scan,
    output logic [2**SEL_W-1:0]   Q,
    output logic [SEL_W-1:0]      Ptr,
    output logic                  Done
);

    mode_e            mode;
    logic [SEL_W-1:0] addr;
    logic             scan_inc;

    // Decode mode, select effective address and detect scan writes
    always_comb begin
        mode     = mode_e'(Mode);
        addr     = Scan ? Ptr : S;
        scan_inc = Scan && En && is_write_mode(mode);
    end

    scan_ptr #(.SEL_W(SEL_W)) u_scan_ptr (
        .clk  (Clk),
        .rst  (Rst),
        .clr  (mode == CLEAR),
        .inc  (scan_inc),
        .ptr  (Ptr),
        .done (Done)
    );

    // Latch contents: single-bit write, one-hot demux load, or clear
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Q <= '0;
        end else begin
            case (mode)
                LATCH: if (En) Q[addr] <= D;
                DEMUX: if (En) begin
                    Q       <= '0;
                    Q[addr] <= D;
                end
                CLEAR: Q <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ttl74259_sync.sv
// Self-checking bench for ttl74259_sync: reference model plus directed vectors.
module tb_ttl74259_sync;

    localparam int NQ = 8;

    logic       clk = 1'b0;
    logic       rst, d, en, scan;
    logic [2:0] s;
    logic [1:0] mode;
    logic [7:0] q;
    logic [2:0] ptr;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q_m;
    int         ptr_m;
    logic       done_m;
    bit         mv = 0;

    ttl74259_sync #(.SEL_W(3)) dut (
        .Clk  (clk),
        .Rst  (rst),
        .D    (d),
        .S    (s),
        .En   (en),
        .Mode (mode),
        .Scan (scan),
        .Q    (q),
        .Ptr  (ptr),
        .Done (done)
    );

    always #5 clk = ~clk;

    // Behavioural model of the latch
    always @(posedge clk) begin
        int a;
        if (rst) begin
            q_m = 8'h00; ptr_m = 0; done_m = 1'b0; mv = 1;
        end else begin
            a = scan ? ptr_m : int'(s);
            done_m = 1'b0;
            if (mode == 2'd1 && en) q_m[a] = d;
            if (mode == 2'd2 && en) q_m = d ? 8'(1 << a) : 8'h00;
            if (mode == 2'd3) begin q_m = 8'h00; ptr_m = 0; end
            if (scan && en && (mode == 2'd1 || mode == 2'd2)) begin
                done_m = (ptr_m == NQ - 1);
                ptr_m  = (ptr_m + 1) % NQ;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (mv) begin
            chk("model_q", 32'(q), 32'(q_m));
            chk("model_ptr", 32'(ptr), 32'(ptr_m));
            chk("model_done", 32'(done), 32'(done_m));
        end
    end

    task automatic cyc(input logic r, input logic [1:0] m, input logic e,
                       input logic dd, input logic sc, input logic [2:0] ss);
        rst = r; mode = m; en = e; d = dd; scan = sc; s = ss;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] q_hold;
        logic [2:0] p_hold;
        int         dcnt;

        pat = 8'h4D;

        // Reset dominates a latch write
        cyc(1, 2'b01, 1, 1, 0, 3'd0);
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_ptr", 32'(ptr), 32'd0);
        chk("reset_done", 32'(done), 32'd0);

        // Addressable latch writes
        cyc(0, 2'b01, 1, 1, 0, 3'd2);
        chk("latch_s2", 32'(q), 32'h04);
        cyc(0, 2'b01, 1, 1, 0, 3'd5);
        chk("latch_s5", 32'(q), 32'h24);
        chk("latch_qs_mirror", 32'(q[5]), 32'd1);
        cyc(0, 2'b01, 1, 0, 0, 3'd2);
        chk("latch_clr_s2", 32'(q), 32'h20);

        // En low holds in latch and demux modes
        cyc(0, 2'b01, 0, 1, 0, 3'd0);
        cyc(0, 2'b10, 0, 1, 1, 3'd1);
        chk("en_low_hold", 32'(q), 32'h20);

        // Fill to FF; non-scan write to top address gives no Done
        for (int i = 0; i < NQ; i++) cyc(0, 2'b01, 1, 1, 0, 3'(i));
        chk("fill_ff", 32'(q), 32'hFF);
        chk("nonscan_top_done", 32'(done), 32'd0);

        // Demux
        cyc(0, 2'b10, 1, 1, 0, 3'd6);
        chk("demux_d1", 32'(q), 32'h40);
        cyc(0, 2'b10, 1, 0, 0, 3'd6);
        chk("demux_d0", 32'(q), 32'h00);

        // Scan word
        cyc(0, 2'b11, 1, 0, 1, 3'd0);
        for (int i = 0; i < NQ; i++) begin
            cyc(0, 2'b01, 1, pat[i], 1, 3'd7);
            chk("scan_done_timing", 32'(done), (i == NQ - 1) ? 32'd1 : 32'd0);
        end
        chk("scan_q", 32'(q), 32'h4D);
        chk("scan_ptr_wrap", 32'(ptr), 32'd0);
        cyc(0, 2'b01, 0, 0, 1, 3'd0);
        chk("scan_done_one_cycle", 32'(done), 32'd0);

        // Clear mid-scan, then a full word
        for (int i = 0; i < 3; i++) cyc(0, 2'b01, 1, 1, 1, 3'd0);
        chk("midscan_ptr3", 32'(ptr), 32'd3);
        cyc(0, 2'b11, 1, 1, 1, 3'd0);
        chk("clear_q", 32'(q), 32'h00);
        chk("clear_ptr", 32'(ptr), 32'd0);
        chk("clear_done", 32'(done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < NQ + 1; i++) begin
            cyc(0, 2'b01, (i < NQ), 1, 1, 3'd0);
            dcnt += int'(done);
        end
        chk("clear_then_word_done", 32'(dcnt), 32'd1);

        // Reset mid-scan, then a full word
        for (int i = 0; i < 3; i++) cyc(0, 2'b10, 1, 1, 1, 3'd0);
        cyc(1, 2'b01, 1, 1, 1, 3'd0);
        chk("rst_mid_q", 32'(q), 32'h00);
        chk("rst_mid_ptr", 32'(ptr), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        dcnt = 0;
        for (int i = 0; i < NQ + 1; i++) begin
            cyc(0, 2'b01, (i < NQ), 0, 1, 3'd0);
            dcnt += int'(done);
        end
        chk("rst_then_word_done", 32'(dcnt), 32'd1);

        // Scan interrupted by a direct write resumes from held pointer
        cyc(0, 2'b11, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) cyc(0, 2'b01, 1, 0, 1, 3'd0);
        cyc(0, 2'b01, 1, 1, 0, 3'd0);
        chk("scan_off_ptr_held", 32'(ptr), 32'd3);
        cyc(0, 2'b01, 1, 1, 1, 3'd0);
        chk("scan_resume_ptr", 32'(ptr), 32'd4);
        chk("scan_resume_q", 32'(q), 32'h09);

        // Back-to-back scan writes: two Done pulses in 16 cycles
        cyc(0, 2'b11, 0, 0, 0, 3'd0);
        dcnt = 0;
        for (int i = 0; i < 2 * NQ; i++) begin
            cyc(0, 2'b10, 1, 1, 1, 3'd0);
            dcnt += int'(done);
        end
        chk("b2b_done_count", 32'(dcnt), 32'd2);
        chk("b2b_q", 32'(q), 32'h80);

        // Hold with random inputs
        cyc(0, 2'b01, 1, 1, 1, 3'd0);
        cyc(0, 2'b01, 1, 1, 1, 3'd0);
        q_hold = q; p_hold = ptr;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 2'b00, 1, 1'($urandom), 1'($urandom), 3'($urandom));
            chk("hold_done", 32'(done), 32'd0);
        end
        chk("hold_q", 32'(q), 32'(q_hold));
        chk("hold_ptr", 32'(ptr), 32'(p_hold));
        chk("hold_q_lit", 32'(q), 32'h83);
        chk("hold_ptr_lit", 32'(ptr), 32'd2);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttl74259_sync.md
TTL74259_SYNC -- requirements
Module: ttl74259_sync

Interface
REQ-001 SHALL have parameter SEL_W, default 3, address width; Q width is 2**SEL_W.
REQ-002 SHALL have port Clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port Rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port D, input, 1: data bit to be written.
REQ-005 SHALL have port S, input, SEL_W: external bit address.
REQ-006 SHALL have port En, input, 1: write strobe, active-high, sampled each Clk edge.
REQ-007 SHALL have port Mode, input, 2: 00 hold, 01 addressable latch, 10 demux, 11 clear.
REQ-008 SHALL have port Scan, input, 1: 1 selects the internal pointer as address; 0 selects S.
REQ-009 SHALL have port Q, output, 2**SEL_W: registered latch contents.
REQ-010 SHALL have port Ptr, output, SEL_W: current internal scan pointer.
REQ-011 SHALL have port Done, output, 1: one-cycle pulse when a scan word completes.

Function
REQ-012 SHALL form the effective address A as Ptr when Scan=1, else S.
REQ-013 SHALL, in Mode 00, hold Q and Ptr regardless of En, D, S and Scan.
REQ-014 SHALL, in Mode 01 with En=1, set Q[A] to D at the edge and leave all other Q bits unchanged.
REQ-015 SHALL, in Mode 10 with En=1, load Q with D at bit A and 0 at every other bit (one-hot demux of D).
REQ-016 SHALL, in Mode 01 or 10 with En=0, hold Q and Ptr.
REQ-017 SHALL, in Mode 11, clear Q to 0 and Ptr to 0 at the edge, irrespective of En and Scan.
REQ-018 SHALL make Q updates visible one Clk cycle after the sampling edge, with no combinational path from inputs to Q.
REQ-019 SHALL increment Ptr by 1 modulo 2**SEL_W on each edge where Scan=1, En=1 and Mode is 01 or 10.
REQ-020 SHALL hold Ptr when Scan=0; S never modifies Ptr.
REQ-021 SHALL, on a scan write with Ptr at all-ones, wrap Ptr to 0 and assert Done for exactly the next cycle.
REQ-022 SHALL keep Done low in every other case, including non-scan writes to the top address.
REQ-023 SHALL let a scan write use the pre-increment Ptr value as A in the same edge.
REQ-024 SHALL allow back-to-back scan writes every cycle; with En held high, Done pulses once every 2**SEL_W cycles.
REQ-025 SHALL give Scan changes mid-word no effect on Ptr; a resumed scan continues from the held Ptr.

Reset
REQ-026 SHALL, while Rst=1 at an edge, set Q=0, Ptr=0 and Done=0.
REQ-027 SHALL give Rst priority over every Mode, En and Scan combination, including Rst asserted mid-scan.
REQ-028 SHALL resume normal operation on the first edge with Rst=0, with Ptr starting at 0.

Structure
REQ-029 SHALL place Mode encodings (HOLD, LATCH, DEMUX, CLEAR) in the shared TTL package as named constants.
REQ-030 SHALL be a single flat module; the Ptr counter with wrap detect may be a sub-module named scan_ptr.
REQ-031 SHALL ensure that, with Mode=01, Scan=0 and a constant S, Q[S] mirrors the bit that ttl74151 selects from Q with the same S.

Verification
REQ-032 Reset: Rst=1 with Mode=01, En=1, D=1 -> Q=00h, Ptr=0, Done=0.
REQ-033 Latch: Mode=01, Scan=0, writes D=1 to S=2, then S=5, then D=0 to S=2 -> Q=04h, 24h, 20h.
REQ-034 Demux: Q=FFh, then Mode=10, En=1, D=1, S=6 -> Q=40h; D=0 -> Q=00h.
REQ-035 Scan: Mode=01, Scan=1, En=1 for 8 cycles with D=1,0,1,1,0,0,1,0 -> Q=4Dh, Ptr=0, Done high exactly 1 cycle after the 8th write.
REQ-036 Clear/reset mid-scan: after 3 scan writes, Mode=11 (or Rst=1) -> Q=00h, Ptr=0, no Done; next 8 scan writes produce one Done.
REQ-037 Hold: Mode=00 with En=1 and random D, S and Scan for 20 cycles -> Q, Ptr unchanged, Done=0.
